hw_loop_ctrl: RTL and testbench
===============================

HW_LOOP_CTRL -- requirements
Module: hw_loop_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- ADDR_W, 32, PC and address width.
- CNT_W, 32, iteration counter width.
- DEPTH, 4, maximum nesting depth (at least 1).

REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clock, in, 1, single clock; all state updates on its rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- pc_cur, in, ADDR_W, PC of the instruction executing this cycle.
- pc_seq, in, ADDR_W, next PC the core would otherwise take (pc+4, branch or jump).
- stall, in, 1, core stalled; no state update this cycle.
- loop_init, in, 1, LOOP instruction executing this cycle.
- init_count, in, CNT_W, unsigned iteration count for a new loop.
- init_start, in, ADDR_W, address of the first body instruction.
- init_end, in, ADDR_W, address of the last body instruction.
- loop_break, in, 1, early exit from the innermost loop.
- pc_next, out, ADDR_W, PC to load on the next edge.
- redirect, out, 1, high when pc_next != pc_seq due to this block.
- depth, out, $clog2(DEPTH+1), number of live frames.
- active, out, 1, depth != 0.
- iter_count, out, CNT_W, remaining count of the innermost frame; 0 when empty.
- overflow_err, out, 1, sticky nesting-overflow flag.

Function
REQ-003 State SHALL be a stack of DEPTH frames {start, end, count} plus depth and overflow_err; top = innermost frame.
REQ-004 pc_next and redirect SHALL be combinational from the current state and inputs (zero-overhead, same-cycle redirect); all state SHALL be registered.
REQ-005 Event priority per cycle SHALL be: loop_break > loop_init > end-match.
REQ-006 Push: on loop_init with init_count >= 1 and depth < DEPTH, push {init_start, init_end, init_count} at the edge; pc_next = pc_seq; redirect = 0.
REQ-007 Zero count: on loop_init with init_count == 0, no push; pc_next = init_end + 4; redirect = 1.
REQ-008 Overflow: on loop_init with init_count >= 1 and depth == DEPTH, no push; overflow_err set at the edge and held until reset; pc_next = pc_seq; the body then executes once.
REQ-009 End-match is defined as depth > 0, pc_cur == top.end, and no loop_break or loop_init this cycle.
REQ-010 On end-match with top.count > 1: pc_next = top.start; redirect = 1; top.count decrements at the edge.
REQ-011 On end-match with top.count == 1: pop the top frame; then evaluate the next frame in the same cycle if it exists and its end == pc_cur:
- if its count > 1: redirect to its start and decrement its count;
- if its count == 1: pop it too, with pc_next = pc_seq.
REQ-012 At most two frames SHALL be popped per cycle; ends shared by three or more levels are unsupported and produce no error flag.
REQ-013 loop_break with depth > 0: pop the top frame; pc_next = top.end + 4; redirect = 1. loop_break with depth == 0: ignored; pc_next = pc_seq.
REQ-014 Address arithmetic (end + 4) SHALL wrap modulo 2^ADDR_W; counts are unsigned and SHALL never decrement below 1.
REQ-015 stall = 1 SHALL block every state update; pc_next and redirect are still driven combinationally and the core ignores them.
REQ-016 With no event, or depth == 0 and no loop_init: pc_next = pc_seq; redirect = 0.

Reset
REQ-017 With reset_n low, asynchronously and independent of clock:
- depth = 0, all frames zeroed, overflow_err = 0, active = 0, iter_count = 0;
- pc_next = pc_seq, redirect = 0.
REQ-018 Reset asserted mid-loop SHALL discard all frames; after release the first loop_init behaves as on an empty stack.

Verification
REQ-019 Single loop: init count=3, start=0x20, end=0x24; drive pc_cur 0x20/0x24 per core -> redirect to 0x20 at 0x24 twice, third pass falls through to pc_seq, depth returns to 0, iter_count reads 3,2,1.
REQ-020 Nested with shared end: outer count=2 (start 0x10, end 0x24), inner count=3 (start 0x20, end 0x24) -> inner body executes 6 times; the final pass at 0x24 pops both frames in one cycle; depth 2 -> 0.
REQ-021 Zero count: init count=0, end=0x40 -> pc_next=0x44, redirect=1, depth stays 0.
REQ-022 Overflow with DEPTH=2: three nested loop_init -> overflow_err=1 and stays 1; depth=2; third body runs once.
REQ-023 Break plus simultaneity:
- loop_break mid-loop (end=0x30) -> pc_next=0x34, depth-1;
- loop_break and loop_init in the same cycle -> break wins, no push.
REQ-024 Stall and reset:
- stall=1 at an end-match -> count unchanged;
- reset_n low mid-loop between clock edges -> outputs clear immediately.

Source files
------------

// File: rtl/hw_loop_ctrl.sv
// Zero-overhead hardware loop controller: a stack of {start, end, count} frames that
// redirects the fetch PC back to a body start in the same cycle the body end executes.
module hw_loop_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32,
    parameter int DEPTH  = 4,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc_cur,
    input  logic [ADDR_W-1:0] pc_seq,
    input  logic              stall,
    input  logic              loop_init,
    input  logic [CNT_W-1:0]  init_count,
    input  logic [ADDR_W-1:0] init_start,
    input  logic [ADDR_W-1:0] init_end,
    input  logic              loop_break,
    output logic [ADDR_W-1:0] pc_next,
    output logic              redirect,
    output logic [DW-1:0]     depth,
    output logic              active,
    output logic [CNT_W-1:0]  iter_count,
    output logic              overflow_err
);

    localparam logic [DW-1:0]     DEPTH_MAX = DW'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);

    logic [ADDR_W-1:0] start_q [DEPTH];
    logic [ADDR_W-1:0] start_d [DEPTH];
    logic [ADDR_W-1:0] end_q   [DEPTH];
    logic [ADDR_W-1:0] end_d   [DEPTH];
    logic [CNT_W-1:0]  cnt_q   [DEPTH];
    logic [CNT_W-1:0]  cnt_d   [DEPTH];
    logic [DW-1:0]     depth_q, depth_d;
    logic              ovf_q, ovf_d;

    int                top_i, sec_i;
    logic [ADDR_W-1:0] top_start, top_end, sec_start, sec_end;
    logic [CNT_W-1:0]  top_cnt, sec_cnt;
    logic              top_vld, sec_vld;

    logic              do_push, pop_top, pop_sec, dec_top, dec_sec;
    logic [ADDR_W-1:0] pc_next_c;
    logic              redirect_c;

    assign top_vld = (depth_q != '0);
    assign sec_vld = (depth_q > DW'(1));

    // Views of the innermost frame and the one beneath it.
    always_comb begin : frame_view
        top_i     = int'(depth_q) - 1;
        sec_i     = int'(depth_q) - 2;
        top_start = '0;
        top_end   = '0;
        top_cnt   = '0;
        sec_start = '0;
        sec_end   = '0;
        sec_cnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == top_i) begin
                top_start = start_q[i];
                top_end   = end_q[i];
                top_cnt   = cnt_q[i];
            end
            if (i == sec_i) begin
                sec_start = start_q[i];
                sec_end   = end_q[i];
                sec_cnt   = cnt_q[i];
            end
        end
    end

    // Event decode: break beats init, init beats end-match.
    always_comb begin : decide
        do_push    = 1'b0;
        pop_top    = 1'b0;
        pop_sec    = 1'b0;
        dec_top    = 1'b0;
        dec_sec    = 1'b0;
        ovf_d      = ovf_q;
        pc_next_c  = pc_seq;
        redirect_c = 1'b0;
        if (loop_break) begin
            if (top_vld) begin
                pop_top    = 1'b1;
                pc_next_c  = top_end + STEP;
                redirect_c = 1'b1;
            end
        end else if (loop_init) begin
            if (init_count == '0) begin
                pc_next_c  = init_end + STEP;
                redirect_c = 1'b1;
            end else if (depth_q < DEPTH_MAX) begin
                do_push = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (top_vld && pc_cur == top_end) begin
            if (top_cnt > ONE) begin
                dec_top    = 1'b1;
                pc_next_c  = top_start;
                redirect_c = 1'b1;
            end else begin
                pop_top = 1'b1;
                // Shared end: the enclosing frame is evaluated in the same cycle.
                if (sec_vld && sec_end == pc_cur) begin
                    if (sec_cnt > ONE) begin
                        dec_sec    = 1'b1;
                        pc_next_c  = sec_start;
                        redirect_c = 1'b1;
                    end else begin
                        pop_sec = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin : apply
        start_d = start_q;
        end_d   = end_q;
        cnt_d   = cnt_q;
        depth_d = depth_q;
        if (do_push) depth_d = depth_q + DW'(1);
        else if (pop_sec) depth_d = depth_q - DW'(2);
        else if (pop_top) depth_d = depth_q - DW'(1);
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && i == int'(depth_q)) begin
                start_d[i] = init_start;
                end_d[i]   = init_end;
                cnt_d[i]   = init_count;
            end
            if ((pop_top && i == top_i) || (pop_sec && i == sec_i)) begin
                start_d[i] = '0;
                end_d[i]   = '0;
                cnt_d[i]   = '0;
            end
            if (dec_top && i == top_i) cnt_d[i] = cnt_q[i] - ONE;
            if (dec_sec && i == sec_i) cnt_d[i] = cnt_q[i] - ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            depth_q <= '0;
            ovf_q   <= 1'b0;
        end else if (!stall) begin
            start_q <= start_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
        end
    end

    // During reset the redirect path is forced quiet regardless of inputs.
    assign pc_next      = reset_n ? pc_next_c : pc_seq;
    assign redirect     = reset_n & redirect_c;
    assign depth        = depth_q;
    assign active       = top_vld;
    assign iter_count   = top_cnt;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_hw_loop_ctrl.sv
// Randomized and directed bench for hw_loop_ctrl against a queue-based loop-stack model.
module tb_hw_loop_ctrl;
    localparam int AW    = 32;
    localparam int CW    = 32;
    localparam int DEPTH = 2;
    localparam int DW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] pc_cur, pc_seq, init_start, init_end;
    logic          stall, loop_init, loop_break;
    logic [CW-1:0] init_count;
    logic [AW-1:0] pc_next;
    logic          redirect, active, overflow_err;
    logic [DW-1:0] depth;
    logic [CW-1:0] iter_count;

    hw_loop_ctrl #(.ADDR_W(AW), .CNT_W(CW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .pc_cur(pc_cur), .pc_seq(pc_seq),
        .stall(stall), .loop_init(loop_init), .init_count(init_count),
        .init_start(init_start), .init_end(init_end), .loop_break(loop_break),
        .pc_next(pc_next), .redirect(redirect), .depth(depth), .active(active),
        .iter_count(iter_count), .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        logic [CW-1:0] c;
    } frame_t;

    frame_t        stk[$];
    logic          m_ovf = 1'b0;
    logic [AW:0]   exp_q[$];
    logic [AW-1:0] obs_pc;
    int            n_cmp = 0;
    int            n_bad = 0;

    logic [AW-1:0] site_pc[2], site_s[2], site_e[2];
    logic [CW-1:0] site_c[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what the stack rules say the next PC is for the current inputs.
    function automatic logic [AW:0] model_pc();
        logic [AW-1:0] pn;
        logic          rd;
        int            n;
        pn = pc_seq;
        rd = 1'b0;
        n  = stk.size();
        if (!reset_n) begin
            rd = 1'b0;
        end else if (loop_break) begin
            if (n > 0) begin pn = stk[n-1].e + 4; rd = 1'b1; end
        end else if (loop_init) begin
            if (init_count == 0) begin pn = init_end + 4; rd = 1'b1; end
        end else if (n > 0 && pc_cur == stk[n-1].e) begin
            if (stk[n-1].c > 1) begin
                pn = stk[n-1].s; rd = 1'b1;
            end else if (n > 1 && stk[n-2].e == pc_cur && stk[n-2].c > 1) begin
                pn = stk[n-2].s; rd = 1'b1;
            end
        end
        return {rd, pn};
    endfunction

    task automatic model_dec_or_pop(output logic popped);
        frame_t f;
        f = stk.pop_back();
        popped = 1'b0;
        if (f.c > 1) begin
            f.c = f.c - 1;
            stk.push_back(f);
        end else begin
            popped = 1'b1;
        end
    endtask

    task automatic model_commit();
        frame_t f;
        logic   popped;
        if (!reset_n) begin
            stk.delete();
            m_ovf = 1'b0;
        end else if (!stall) begin
            if (loop_break) begin
                if (stk.size() > 0) f = stk.pop_back();
            end else if (loop_init) begin
                if (init_count != 0) begin
                    if (stk.size() < DEPTH) begin
                        f.s = init_start; f.e = init_end; f.c = init_count;
                        stk.push_back(f);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end else if (stk.size() > 0 && pc_cur == stk[stk.size()-1].e) begin
                model_dec_or_pop(popped);
                if (popped && stk.size() > 0 && stk[stk.size()-1].e == pc_cur)
                    model_dec_or_pop(popped);
            end
        end
    endtask

    task automatic drive(input logic [AW-1:0] pc, input logic [AW-1:0] seq, input logic init,
                         input logic [CW-1:0] cnt, input logic [AW-1:0] s, input logic [AW-1:0] e,
                         input logic brk, input logic stl);
        pc_cur = pc; pc_seq = seq; loop_init = init; init_count = cnt;
        init_start = s; init_end = e; loop_break = brk; stall = stl;
    endtask

    task automatic set_reset(input logic v);
        reset_n = v;
        if (!v) begin stk.delete(); m_ovf = 1'b0; end
    endtask

    task automatic cycle(input string tag);
        logic [AW:0] e;
        int          n;
        @(negedge clock);
        exp_q.push_back(model_pc());
        e = exp_q.pop_front();
        n = stk.size();
        obs_pc = pc_next;
        check({tag, ".pc"}, pc_next, e[AW-1:0]);
        check({tag, ".redir"}, redirect, e[AW]);
        check({tag, ".depth"}, depth, n);
        check({tag, ".active"}, active, n != 0);
        check({tag, ".iter"}, iter_count, (n > 0) ? stk[n-1].c : 0);
        check({tag, ".ovf"}, overflow_err, m_ovf);
        @(posedge clock);
        model_commit();
        #1;
    endtask

    task automatic run(input logic [AW-1:0] pc, input string tag);
        drive(pc, pc + 4, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle(tag);
    endtask

    // Core emulation: follow pc_next from start until stop, issuing LOOPs at the site PCs.
    task automatic follow(input logic [AW-1:0] start, input logic [AW-1:0] stop,
                          input logic [AW-1:0] hit_pc, input string tag,
                          output int hits, output int max_depth);
        logic [AW-1:0] pc;
        int            budget;
        pc = start; hits = 0; max_depth = 0; budget = 100;
        while (pc != stop && budget > 0) begin
            drive(pc, pc + 4, 1'b0, '0, '0, '0, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++)
                if (pc == site_pc[k]) begin
                    loop_init = 1'b1; init_count = site_c[k];
                    init_start = site_s[k]; init_end = site_e[k];
                end
            if (pc == hit_pc) hits++;
            cycle(tag);
            if (int'(depth) > max_depth) max_depth = int'(depth);
            pc = obs_pc;
            budget--;
        end
        if (budget == 0) check({tag, ".budget"}, 1, 0);
    endtask

    initial begin
        int hits, maxd;
        drive(32'h0, 32'h4, 1'b1, '0, 32'h0, 32'h40, 1'b0, 1'b0);
        set_reset(1'b0);
        cycle("rst0");
        cycle("rst1");
        set_reset(1'b1);

        // Single loop, count 3.
        site_pc[0] = 32'h1C; site_c[0] = 3; site_s[0] = 32'h20; site_e[0] = 32'h24;
        site_pc[1] = 32'hFFFF_FFF0; site_c[1] = 1; site_s[1] = '0; site_e[1] = '0;
        follow(32'h1C, 32'h28, 32'h20, "single", hits, maxd);
        check("single.hits", hits, 3);
        check("single.depth_end", depth, 0);

        // Nested loops sharing an end address.
        site_pc[0] = 32'h0C; site_c[0] = 2; site_s[0] = 32'h10; site_e[0] = 32'h24;
        site_pc[1] = 32'h14; site_c[1] = 3; site_s[1] = 32'h20; site_e[1] = 32'h24;
        follow(32'h0C, 32'h28, 32'h20, "nested", hits, maxd);
        check("nested.hits", hits, 6);
        check("nested.maxdepth", maxd, 2);
        check("nested.depth_end", depth, 0);

        // Zero count skip, including address wrap.
        drive(32'h3C, 32'h40, 1'b1, 0, 32'h30, 32'h40, 1'b0, 1'b0);
        cycle("zero");
        check("zero.pc_hold", obs_pc, 32'h44);
        drive(32'h8, 32'hC, 1'b1, 0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        cycle("zero_wrap");
        check("zero_wrap.pc", obs_pc, 32'h0);

        // Overflow on third nested LOOP.
        drive(32'hFC, 32'h100, 1'b1, 2, 32'h100, 32'h120, 1'b0, 1'b0); cycle("ovf_a");
        drive(32'h100, 32'h104, 1'b1, 2, 32'h104, 32'h11C, 1'b0, 1'b0); cycle("ovf_b");
        drive(32'h104, 32'h108, 1'b1, 2, 32'h108, 32'h118, 1'b0, 1'b0); cycle("ovf_c");
        for (int a = 32'h108; a <= 32'h11C; a += 4) run(AW'(a), "ovf_body");
        check("ovf.sticky", overflow_err, 1);
        check("ovf.depth", depth, 2);
        set_reset(1'b0); cycle("ovf_rst"); set_reset(1'b1);
        check("ovf.cleared", overflow_err, 0);

        // Break mid-loop, break at empty, break beats init.
        drive(32'h24, 32'h28, 1'b1, 5, 32'h28, 32'h30, 1'b0, 1'b0); cycle("brk_init");
        run(32'h28, "brk_body");
        drive(32'h2C, 32'h30, 1'b0, 0, 0, 0, 1'b1, 1'b0); cycle("brk");
        check("brk.pc", obs_pc, 32'h34);
        drive(32'h34, 32'h38, 1'b0, 0, 0, 0, 1'b1, 1'b0); cycle("brk_empty");
        drive(32'h24, 32'h28, 1'b1, 5, 32'h28, 32'h30, 1'b0, 1'b0); cycle("brk_init2");
        drive(32'h28, 32'h2C, 1'b1, 4, 32'h2C, 32'h30, 1'b1, 1'b0); cycle("brk_vs_init");
        check("brk_vs_init.depth", depth, 0);

        // Stall at an end-match, then async reset mid-loop.
        drive(32'h4C, 32'h50, 1'b1, 3, 32'h50, 32'h54, 1'b0, 1'b0); cycle("stl_init");
        run(32'h50, "stl_body");
        drive(32'h54, 32'h58, 1'b0, 0, 0, 0, 1'b0, 1'b1); cycle("stl_end");
        check("stl.count", iter_count, 3);
        run(32'h54, "stl_go");
        run(32'h50, "stl_body2");
        drive(32'h54, 32'h58, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        #2;
        set_reset(1'b0);
        #1;
        check("arst.depth", depth, 0);
        check("arst.active", active, 0);
        check("arst.iter", iter_count, 0);
        check("arst.redir", redirect, 0);
        check("arst.pc", pc_next, 32'h58);
        cycle("arst");
        set_reset(1'b1);
        drive(32'h4C, 32'h50, 1'b1, 2, 32'h50, 32'h54, 1'b0, 1'b0); cycle("arst_init");
        check("arst.fresh_depth", depth, 1);

        // Randomized traffic around a few loop addresses.
        for (int t = 0; t < 600; t++) begin
            logic [AW-1:0] pc;
            case ($urandom_range(0, 5))
                0: pc = 32'h10;
                1: pc = 32'h14;
                2: pc = 32'h20;
                3: pc = 32'h24;
                4: pc = 32'h30;
                default: pc = $urandom;
            endcase
            drive(pc, $urandom, ($urandom_range(0, 7) == 0), CW'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? 32'h10 : 32'h20,
                  ($urandom_range(0, 1) != 0) ? 32'h24 : 32'h30,
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 99) == 0) set_reset(1'b0);
            cycle("rand");
            if (!reset_n) set_reset(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
